// File: rtl/prog_loader.sv
// Byte-stream image loader: writes a checksummed frame into the 16x8 program RAM
// and holds the CPU in reset until a good image has landed.
module prog_loader #(
  parameter logic [3:0] MAGIC = 4'hA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ram_we,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       cpu_reset,
  output logic       done,
  output logic       err,
  output logic [4:0] words_loaded
);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    CHECK,
    RUN,
    ERROR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] sum;
  logic              accept;
  logic              header;

  assign accept = in_valid && in_ready;
  assign header = (in_data[7:4] == MAGIC);

  // Single-process FSM; every output is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_idx     <= '0;
      addr         <= '0;
      sum          <= '0;
      in_ready     <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      in_ready <= 1'b1;
      ram_we   <= 1'b0;
      if (accept) begin
        case (state)
          IDLE, RUN, ERROR: begin
            if (header) begin
              last_idx     <= in_data[3:0];
              sum          <= '0;
              addr         <= '0;
              words_loaded <= '0;
              done         <= 1'b0;
              err          <= 1'b0;
              cpu_reset    <= 1'b1;
              state        <= DATA;
            end
          end
          DATA: begin
            ram_we       <= 1'b1;
            ram_addr     <= addr;
            ram_wdata    <= in_data;
            sum          <= DATA_W'(sum + in_data);
            words_loaded <= 5'(words_loaded + 5'd1);
            // The address saturates at 15; the frame length guarantees CHECK follows.
            if (addr != 4'hF) addr <= 4'(addr + 4'd1);
            if (addr == last_idx) state <= CHECK;
          end
          CHECK: begin
            if (DATA_W'(sum + in_data) == 8'd0) begin
              done      <= 1'b1;
              cpu_reset <= 1'b0;
              state     <= RUN;
            end else begin
              err   <= 1'b1;
              state <= ERROR;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a small frame model predicts RAM writes and status.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_reset;
  logic       done;
  logic       err;
  logic [4:0] words_loaded;

  prog_loader #(.MAGIC(4'hA)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_reset(cpu_reset), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         wr_cyc[$];
  logic [7:0] shadow[16];
  logic [7:0] seen[16];

  typedef enum {M_IDLE, M_DATA, M_CHECK, M_RUN, M_ERR} mst_t;
  mst_t       m_st;
  int         m_n;
  int         m_cnt;
  logic [7:0] m_sum;

  // Expected {done, err, cpu_reset, words_loaded} from the model state.
  function automatic logic [7:0] exp_status();
    logic d;
    logic e;
    d = (m_st == M_RUN);
    e = (m_st == M_ERR);
    return {d, e, ~d, 5'(m_cnt)};
  endfunction

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_t e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write got addr=%h data=%h, required no write", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({ram_addr, ram_wdata} !== e) begin
          miscompares++;
          $display("FAIL ram_write got addr=%h data=%h, required addr=%h data=%h",
                   ram_addr, ram_wdata, e.addr, e.data);
        end
      end
      seen[ram_addr] = ram_wdata;
      wr_cyc.push_back(cyc);
    end
  end

  task automatic model_reset();
    m_st  = M_IDLE;
    m_cnt = 0;
    m_n   = 0;
    m_sum = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (m_st)
      M_IDLE, M_RUN, M_ERR: begin
        if (b[7:4] == 4'hA) begin
          m_n   = int'(b[3:0]) + 1;
          m_cnt = 0;
          m_sum = 8'h00;
          m_st  = M_DATA;
        end
      end
      M_DATA: begin
        exp_q.push_back({4'(m_cnt), b});
        shadow[m_cnt] = b;
        m_sum = 8'(m_sum + b);
        m_cnt++;
        if (m_cnt == m_n) m_st = M_CHECK;
      end
      M_CHECK: m_st = (8'(m_sum + b) == 8'h00) ? M_RUN : M_ERR;
      default: m_st = M_IDLE;
    endcase
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    model_byte(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA0;
    @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, ram_we, ram_addr, ram_wdata, cpu_reset, done, err, words_loaded} !==
        {1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_values got rdy=%b we=%b a=%h d=%h cpu=%b done=%b err=%b wl=%0d",
               in_ready, ram_we, ram_addr, ram_wdata, cpu_reset, done, err, words_loaded);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, done, err, cpu_reset, words_loaded} !== {1'b1, exp_status()}) begin
      miscompares++;
      $display("FAIL post_reset got rdy=%b done=%b err=%b cpu=%b wl=%0d, required rdy=1 idle",
               in_ready, done, err, cpu_reset, words_loaded);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d[4];
    logic [7:0] s;
    d = '{8'h86, 8'h45, 8'h21, 8'h97};
    s = 8'h00;
    foreach (d[i]) s = 8'(s + d[i]);
    wr_cyc.delete();
    send(8'hA3);
    foreach (d[i]) send(d[i]);
    send(8'(~s + 8'd1));
    vectors++;
    if ({done, err, cpu_reset, words_loaded} !== {1'b1, 1'b0, 1'b0, 5'd4} ||
        {done, err, cpu_reset, words_loaded} !== exp_status()) begin
      miscompares++;
      $display("FAIL basic_status got done=%b err=%b cpu=%b wl=%0d, required 1 0 0 4",
               done, err, cpu_reset, words_loaded);
    end
    idle(2);
    vectors++;
    if (exp_q.size() != 0 || wr_cyc.size() != 4 || (wr_cyc.size() == 4 && wr_cyc[3] - wr_cyc[0] != 3)) begin
      miscompares++;
      $display("FAIL basic_b2b got %0d writes (%0d pending), required 4 consecutive",
               wr_cyc.size(), exp_q.size());
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] d[4];
    logic [7:0] s;
    d = '{8'h86, 8'h45, 8'h21, 8'h97};
    s = 8'h00;
    foreach (d[i]) s = 8'(s + d[i]);
    apply_reset();
    send(8'hA3);
    foreach (d[i]) send(d[i]);
    send(8'(~s + 8'd2));
    vectors++;
    if ({done, err, cpu_reset, words_loaded} !== {1'b0, 1'b1, 1'b1, 5'd4} ||
        {done, err, cpu_reset, words_loaded} !== exp_status()) begin
      miscompares++;
      $display("FAIL bad_status got done=%b err=%b cpu=%b wl=%0d, required 0 1 1 4",
               done, err, cpu_reset, words_loaded);
    end
    idle(2);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (seen[i] !== shadow[i]) begin
        miscompares++;
        $display("FAIL bad_ram[%0d] got %h, required %h", i, seen[i], shadow[i]);
      end
    end
  endtask

  task automatic test_full_wrap();
    send(8'hAF);
    for (int i = 0; i < 16; i++) send(8'hFF);
    send(8'h10);
    vectors++;
    if ({done, err, cpu_reset, words_loaded} !== {1'b1, 1'b0, 1'b0, 5'd16} ||
        {done, err, cpu_reset, words_loaded} !== exp_status()) begin
      miscompares++;
      $display("FAIL full_status got done=%b err=%b cpu=%b wl=%0d, required 1 0 0 16",
               done, err, cpu_reset, words_loaded);
    end
    idle(3);
    vectors++;
    if (exp_q.size() != 0 || seen[15] !== 8'hFF) begin
      miscompares++;
      $display("FAIL full_drain got pending=%0d ram15=%h, required 0 and ff", exp_q.size(), seen[15]);
    end
  endtask

  task automatic test_gaps();
    apply_reset();
    send(8'h00);
    idle(1);
    send(8'h5F);
    idle(1);
    vectors++;
    if ({done, err, cpu_reset, words_loaded} !== exp_status() || ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL garbage got done=%b err=%b cpu=%b wl=%0d we=%b, required idle",
               done, err, cpu_reset, words_loaded, ram_we);
    end
    send(8'hA0);
    idle(1);
    send(8'h07);
    idle(1);
    send(8'hF9);
    idle(2);
    vectors++;
    if ({done, err, cpu_reset, words_loaded} !== {1'b1, 1'b0, 1'b0, 5'd1} || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL gaps_status got done=%b err=%b cpu=%b wl=%0d pending=%0d, required 1 0 0 1 0",
               done, err, cpu_reset, words_loaded, exp_q.size());
    end
  endtask

  task automatic test_reload();
    send(8'hA1);
    vectors++;
    if ({cpu_reset, done, err} !== 3'b100) begin
      miscompares++;
      $display("FAIL reload_hdr got cpu=%b done=%b err=%b, required 1 0 0", cpu_reset, done, err);
    end
    send(8'h11);
    send(8'h22);
    send(8'hCD);
    idle(2);
    vectors++;
    if ({done, cpu_reset, words_loaded, seen[0], seen[1]} !== {1'b1, 1'b0, 5'd2, 8'h11, 8'h22}) begin
      miscompares++;
      $display("FAIL reload_done got done=%b cpu=%b wl=%0d ram0=%h ram1=%h, required 1 0 2 11 22",
               done, cpu_reset, words_loaded, seen[0], seen[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] keep2;
    keep2 = seen[2];
    send(8'hA3);
    send(8'h01);
    send(8'h02);
    in_data  = 8'h03;
    in_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    vectors++;
    if ({ram_we, cpu_reset, done, err, words_loaded} !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL mid_reset got we=%b cpu=%b done=%b err=%b wl=%0d, required 0 1 0 0 0",
               ram_we, cpu_reset, done, err, words_loaded);
    end
    idle(1);
    vectors++;
    if ({seen[0], seen[1], seen[2]} !== {8'h01, 8'h02, keep2} || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_ram got %h %h %h, required 01 02 %h", seen[0], seen[1], seen[2], keep2);
    end
    send(8'hA1);
    send(8'h5A);
    send(8'h6B);
    send(8'(~8'(8'h5A + 8'h6B) + 8'd1));
    idle(2);
    vectors++;
    if ({done, err, cpu_reset, words_loaded} !== {1'b1, 1'b0, 1'b0, 5'd2} || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_reload got done=%b err=%b cpu=%b wl=%0d, required 1 0 0 2",
               done, err, cpu_reset, words_loaded);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      shadow[i] = 8'h00;
      seen[i]   = 8'h00;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    model_reset();
    #1;
    test_reset();
    test_basic();
    test_bad_checksum();
    test_full_wrap();
    test_gaps();
    test_reload();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
